// File: rtl/reg_file_wr_arbiter.sv
// Write-port owner for the register bank: round-robin arbitration between
// N_REQ valid/ready writers, plus a bulk CLEAR sequence that zeroes every register.
module reg_file_wr_arbiter #(
  parameter int N_REQ    = 3,
  parameter int NUM_REGS = 14,
  parameter int AW       = 4,
  parameter int DW       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic                clr_start,
  output logic                clr_busy,
  output logic                clr_done,
  output logic                err_addr,
  output logic [2:0]          err_id,
  output logic                rf_we,
  output logic [AW-1:0]       rf_addr_wr,
  output logic [DW-1:0]       rf_data_in
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REGS - 1);

  typedef enum logic {RUN, CLEAR} state_t;

  state_t          state_q;
  logic [PW-1:0]   rr_ptr_q;
  logic            rf_we_q;
  logic [AW-1:0]   rf_addr_q;
  logic [DW-1:0]   rf_data_q;
  logic            clr_done_q;
  logic            err_addr_q;
  logic [2:0]      err_id_q;

  logic            gnt_vld;
  logic [PW-1:0]   gnt_idx;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_data;
  logic            gnt_legal;
  logic [PW-1:0]   rr_ptr_d;
  int              cand;

  // Search downward over offsets so the nearest requester at/after rr_ptr wins.
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    req_ready = '0;
    if (state_q == RUN && !clr_start) begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        cand = (int'(rr_ptr_q) + k) % N_REQ;
        if (req_valid[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = PW'(cand);
        end
      end
    end
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
    gnt_addr  = req_addr[gnt_idx*AW +: AW];
    gnt_data  = req_data[gnt_idx*DW +: DW];
    gnt_legal = (int'(gnt_addr) < NUM_REGS);
    rr_ptr_d  = PW'((int'(gnt_idx) + 1) % N_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      clr_done_q <= 1'b0;
      err_addr_q <= 1'b0;
      err_id_q   <= '0;
    end else begin
      rf_we_q    <= 1'b0;
      clr_done_q <= 1'b0;
      err_addr_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (clr_start) begin
            state_q   <= CLEAR;
            rf_we_q   <= 1'b1;
            rf_addr_q <= '0;
            rf_data_q <= '0;
          end else if (gnt_vld) begin
            rr_ptr_q <= rr_ptr_d;
            // Illegal addresses are consumed but never reach the bank.
            if (gnt_legal) begin
              rf_we_q   <= 1'b1;
              rf_addr_q <= gnt_addr;
              rf_data_q <= gnt_data;
            end else begin
              err_addr_q <= 1'b1;
              err_id_q   <= 3'(gnt_idx);
            end
          end
        end
        CLEAR: begin
          if (rf_addr_q == LAST_ADDR) begin
            state_q    <= RUN;
            clr_done_q <= 1'b1;
          end else begin
            rf_we_q   <= 1'b1;
            rf_addr_q <= rf_addr_q + AW'(1);
            rf_data_q <= '0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign clr_busy   = (state_q == CLEAR);
  assign clr_done   = clr_done_q;
  assign err_addr   = err_addr_q;
  assign err_id     = err_id_q;
  assign rf_we      = rf_we_q;
  assign rf_addr_wr = rf_addr_q;
  assign rf_data_in = rf_data_q;

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Directed bench for reg_file_wr_arbiter: arbitration order, illegal
// addresses, CLEAR sequence, reset abort and ignored re-start.
module tb_reg_file_wr_arbiter;
  localparam int N_REQ = 3;
  localparam int AW    = 4;
  localparam int DW    = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_data;
  logic                clr_start;
  logic                clr_busy;
  logic                clr_done;
  logic                err_addr;
  logic [2:0]          err_id;
  logic                rf_we;
  logic [AW-1:0]       rf_addr_wr;
  logic [DW-1:0]       rf_data_in;

  int n_tests = 0;
  int n_fail  = 0;

  reg_file_wr_arbiter #(.N_REQ(N_REQ), .NUM_REGS(14), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .clr_start(clr_start),
    .clr_busy(clr_busy), .clr_done(clr_done), .err_addr(err_addr),
    .err_id(err_id), .rf_we(rf_we), .rf_addr_wr(rf_addr_wr),
    .rf_data_in(rf_data_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; clr_start = 1'b0;
    tick(); tick();
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_addr", 32'(rf_addr_wr), 0);
    chk("rst_data", 32'(rf_data_in), 0);
    chk("rst_busy", 32'(clr_busy), 0);
    chk("rst_done", 32'(clr_done), 0);
    chk("rst_err", 32'(err_addr), 0);
    chk("rst_errid", 32'(err_id), 0);
    rst = 1'b0;

    // Test 1: single requester
    req_valid = 3'b001; req_addr[3:0] = 4'd5; req_data[15:0] = 16'hBEEF;
    settle();
    chk("t1_ready", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    chk("t1_we", 32'(rf_we), 1);
    chk("t1_addr", 32'(rf_addr_wr), 5);
    chk("t1_data", 32'(rf_data_in), 32'hBEEF);

    // Bring rr_ptr from 1 back to 0 via requester 2
    req_addr = {4'd3, 4'd2, 4'd1};
    req_data = {16'hA002, 16'hA001, 16'hA000};
    req_valid = 3'b100;
    settle();
    chk("t2_pre_ready", 32'(req_ready), 32'b100);
    tick();
    chk("t2_pre_addr", 32'(rf_addr_wr), 3);

    // Test 2: all valid for 6 cycles -> 0,1,2,0,1,2
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk($sformatf("t2_ready%0d", k), 32'(req_ready), 32'(1 << (k % 3)));
      tick();
      chk($sformatf("t2_we%0d", k), 32'(rf_we), 1);
      chk($sformatf("t2_addr%0d", k), 32'(rf_addr_wr), 32'((k % 3) + 1));
      chk($sformatf("t2_data%0d", k), 32'(rf_data_in), 32'(16'hA000 + (k % 3)));
    end
    req_valid = '0;
    tick();
    chk("t2_idle_we", 32'(rf_we), 0);

    // Test 3: illegal address from requester 1
    req_addr[7:4] = 4'd14;
    req_valid = 3'b010;
    settle();
    chk("t3_ready", 32'(req_ready), 32'b010);
    tick();
    chk("t3_we", 32'(rf_we), 0);
    chk("t3_err", 32'(err_addr), 1);
    chk("t3_errid", 32'(err_id), 1);
    req_addr[7:4] = 4'd2;
    req_valid = 3'b111;
    settle();
    chk("t3_next_ready", 32'(req_ready), 32'b100);
    tick();
    req_valid = '0;
    chk("t3_err_pulse", 32'(err_addr), 0);
    chk("t3_errid_hold", 32'(err_id), 1);
    chk("t3_we2", 32'(rf_we), 1);
    chk("t3_addr2", 32'(rf_addr_wr), 3);

    // Test 4: CLEAR with all requesters valid (rr_ptr = 0)
    req_valid = 3'b111; clr_start = 1'b1;
    settle();
    chk("t4_ready_start", 32'(req_ready), 0);
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      settle();
      chk($sformatf("t4_ready%0d", k), 32'(req_ready), 0);
      chk($sformatf("t4_busy%0d", k), 32'(clr_busy), 1);
      chk($sformatf("t4_we%0d", k), 32'(rf_we), 1);
      chk($sformatf("t4_addr%0d", k), 32'(rf_addr_wr), 32'(k));
      chk($sformatf("t4_data%0d", k), 32'(rf_data_in), 0);
      chk($sformatf("t4_done%0d", k), 32'(clr_done), 0);
      tick();
    end
    chk("t4_done", 32'(clr_done), 1);
    chk("t4_busy_end", 32'(clr_busy), 0);
    chk("t4_we_end", 32'(rf_we), 0);
    chk("t4_ready_after", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    chk("t4_done_pulse", 32'(clr_done), 0);
    chk("t4_grant_addr", 32'(rf_addr_wr), 1);
    chk("t4_grant_we", 32'(rf_we), 1);

    // Test 6: clr_start pulsed mid-CLEAR is ignored
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("t6_addr%0d", k), 32'(rf_addr_wr), 32'(k));
      chk($sformatf("t6_busy%0d", k), 32'(clr_busy), 1);
      clr_start = (k == 5);
      tick();
      clr_start = 1'b0;
    end
    chk("t6_done", 32'(clr_done), 1);
    chk("t6_busy_end", 32'(clr_busy), 0);
    tick();
    chk("t6_done_pulse", 32'(clr_done), 0);
    chk("t6_we_idle", 32'(rf_we), 0);
    chk("t6_busy_idle", 32'(clr_busy), 0);

    // Test 5: reset at CLEAR address 6 (rr_ptr is 1 beforehand)
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("t5_addr%0d", k), 32'(rf_addr_wr), 32'(k));
      if (k == 6) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    chk("t5_busy", 32'(clr_busy), 0);
    chk("t5_we", 32'(rf_we), 0);
    chk("t5_done", 32'(clr_done), 0);
    chk("t5_addr_rst", 32'(rf_addr_wr), 0);
    tick();
    chk("t5_done_late", 32'(clr_done), 0);
    chk("t5_we_late", 32'(rf_we), 0);
    req_valid = 3'b111;
    settle();
    chk("t5_rrptr", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    chk("t5_grant_addr", 32'(rf_addr_wr), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end
endmodule
